// File: rtl/uc_arbitro_mem_tiro.sv
// Round-robin arbiter for the shot position / loaded-flag memory pair.
// Grants one of three requesters, drives the port mux and revokes stuck owners.
module uc_arbitro_mem_tiro #(
    parameter int unsigned MAX_HOLD = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req_i,
    input  logic [2:0] done_i,
    output logic [2:0] grant_o,
    output logic [1:0] sel_mem_o,
    output logic       busy_o,
    output logic       erro_timeout_o,
    output logic [3:0] db_estado_arbitro_o
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd1,
        CONCEDE = 2'd2,
        LIBERA  = 2'd3
    } estado_t;

    localparam logic [7:0] LIMITE = 8'(MAX_HOLD - 1);

    estado_t    estado_q;
    logic [1:0] owner_q;
    logic [1:0] rr_ptr_q;
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    logic [1:0] vencedor;
    logic [3:0] done_ext;
    logic       done_dono;

    assign done_ext  = {1'b0, done_i};
    assign done_dono = done_ext[owner_q];

    // Lowest priority is evaluated first so the search start wins last.
    always_comb begin
        int p;
        vencedor = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            p = int'(rr_ptr_q) + k;
            if (p >= 3) p = p - 3;
            if (req_i[p]) vencedor = 2'(p);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (|req_i) begin
                        estado_q   <= CONCEDE;
                        owner_q    <= vencedor;
                        hold_cnt_q <= 8'd0;
                    end
                end
                CONCEDE: begin
                    hold_cnt_q <= hold_cnt_q + 8'd1;
                    if (done_dono) begin
                        estado_q  <= LIBERA;
                        timeout_q <= 1'b0;
                    end else if (hold_cnt_q == LIMITE) begin
                        estado_q  <= LIBERA;
                        timeout_q <= 1'b1;
                    end
                end
                LIBERA: begin
                    rr_ptr_q <= (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
                    estado_q <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    always_comb begin
        grant_o             = 3'b000;
        sel_mem_o           = 2'b11;
        busy_o              = 1'b1;
        erro_timeout_o      = 1'b0;
        db_estado_arbitro_o = 4'hD;
        case (estado_q)
            OCIOSO: begin
                busy_o              = 1'b0;
                db_estado_arbitro_o = 4'h1;
            end
            CONCEDE: begin
                grant_o             = 3'b001 << owner_q;
                sel_mem_o           = owner_q;
                db_estado_arbitro_o = 4'h2;
            end
            LIBERA: begin
                erro_timeout_o      = timeout_q;
                db_estado_arbitro_o = 4'h3;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/uc_arbitro_mem_tiro.md
# uc_arbitro_mem_tiro

Round-robin arbiter and access sequencer for the shot memory pair (position memory and loaded-flag memory). Three requesters share it: 0 = shot registration, 1 = shot movement update, 2 = collision check. The block grants exclusive ownership to one requester at a time and drives the memory-port mux select. It also revokes ownership from a requester that holds the memory too long.

## Interface
- MAX_HOLD, 32, maximum cycles an owner may stay granted before forced release (legal range 2..255)
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- req  input  3  request per requester (bit i = requester i), level-sensitive
- done  input  3  owner finished; only the bit of the current owner is honoured
- grant  output  3  one-hot ownership grant, Moore output
- sel_mem  output  2  memory-port mux select: owner index while granted, 2'b11 otherwise
- busy  output  1  high in every state except OCIOSO
- erro_timeout  output  1  one-cycle pulse when an owner was forcibly released
- db_estado_arbitro  output  4  debug state code

## Operation
- Registered state:
  - FSM state.
  - owner[1:0]: index of the granted requester.
  - rr_ptr[1:0]: first requester to search, range 0..2.
  - hold_cnt[7:0].
  - timeout flag.
- States and debug codes:
  - OCIOSO: 4'h1.
  - CONCEDE: 4'h2.
  - LIBERA: 4'h3.
  - Any illegal encoding shows 4'hD on db_estado_arbitro and returns to OCIOSO on the next edge.
- OCIOSO:
  - If req != 0, the winner is the first set bit searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Next state is CONCEDE; owner <= winner; hold_cnt <= 0.
  - Otherwise stay in OCIOSO.
- CONCEDE:
  - grant = one-hot(owner); sel_mem = owner.
  - hold_cnt increments every cycle.
  - If done[owner], go to LIBERA with timeout flag <= 0.
  - Else if hold_cnt == MAX_HOLD-1, go to LIBERA with timeout flag <= 1.
  - Else stay in CONCEDE.
- LIBERA:
  - grant = 0; sel_mem = 2'b11.
  - erro_timeout = timeout flag.
  - rr_ptr <= (owner == 2) ? 0 : owner+1.
  - Unconditionally go to OCIOSO.
- Ignored inputs:
  - done bits of non-owners are always ignored.
  - Dropping req while granted does not release ownership; only done or timeout releases it.
- grant is never multi-hot, and is zero outside CONCEDE.
- Reset values, applied immediately and asynchronously:
  - state OCIOSO; owner 0; rr_ptr 0; hold_cnt 0; timeout flag 0.
  - grant 3'b000, sel_mem 2'b11, busy 0, erro_timeout 0, db_estado_arbitro 4'h1.
  - Reset mid-grant drops grant in the same cycle. No LIBERA or timeout pulse is produced.

## Timing
- Grant latency:
  - req sampled high at edge E0 while in OCIOSO → grant high during the cycle after E0.
- Release latency:
  - done sampled high at edge E1 → grant low after E1 (LIBERA).
  - OCIOSO after E1+1.
  - Earliest next grant after E1+2; minimum 2 dead cycles between owners.
- done asserted in the first CONCEDE cycle is honoured: minimum grant length is 1 cycle.
- Timeout:
  - With no done, grant lasts exactly MAX_HOLD cycles.
  - erro_timeout pulses in the single LIBERA cycle that follows.
- done and the timeout condition in the same cycle: done wins, so there is no erro_timeout pulse.
- Simultaneous requests resolve in one cycle according to rr_ptr.
- A requester that keeps req high is re-granted only after every other pending requester has been served once.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.

## Test plan
- Reset, then req=3'b010 held until grant=3'b010, done[1] for 1 cycle → grant after 1 cycle, sel_mem=2'b01, grant low 1 cycle after done, busy back to 0 two cycles after done, rr_ptr=2.
- Reset, req=3'b111 held, each owner pulses done on its 2nd granted cycle → grant order 001, 010, 100, 001, with 2 idle-grant cycles between each.
- MAX_HOLD=4, req[2] high, done never → grant=3'b100 for exactly 4 cycles, erro_timeout one pulse, then re-grant to 2 if req still high.
- Owner 0 granted, done=3'b110 pulsed → ignored, grant stays 3'b001; then done[0] on the MAX_HOLD-1 cycle → release with erro_timeout=0.
- Owner 1 granted, req[1] dropped → grant held; reset asserted mid-CONCEDE → grant=0, sel_mem=2'b11, busy=0 immediately; after reset with req=3'b110, requester 1 is granted first (rr_ptr=0).
